// File: rtl/btn_pkg.sv
// Shared button-path definitions: default sizes, tick divider and button index type.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package btn_pkg;
  localparam int NUM_BTN_DEFAULT     = 4;
  localparam int ID_W_DEFAULT        = 2;
  localparam int FIFO_DEPTH_DEFAULT  = 4;
  // 10 ms sample period at 25 MHz
  localparam int TICK_DIV_25MHZ_10MS = 250000;

  typedef logic [ID_W_DEFAULT-1:0] btn_id_t;
endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with occupancy count; storage and pointers are cleared on reset.
// Latency: a push is visible at pop_dat/empty one cycle later; head read is combinational from registers.
// Backpressure: push is dropped when full, pop is ignored when empty; full is judged on the pre-pop count.
// Ports: clk, rst (async, active-high), push/push_dat, pop/pop_dat, empty, count.
module sync_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign pop_dat = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/button_event_scheduler.sv
// Paces the debounce FSMs with sample_tick and serialises their pulses into a button-ID event stream.
// Latency: pulse in cycle t -> pending at edge t+1 -> grant/push at edge t+2 -> evt_valid in cycle t+2.
// Backpressure: evt_valid/evt_ready; while the FIFO is full pending flags are held and repeat presses merge (overflow).
// Ports: clk, rst (async, active-high), btn_pulse, sample_tick, evt_valid/evt_id/evt_ready,
//        pending (debug), overflow (sticky) with overflow_clr.
module button_event_scheduler
  import btn_pkg::*;
#(
  parameter int NUM_BTN    = NUM_BTN_DEFAULT,
  parameter int ID_W       = ID_W_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int TICK_DIV   = TICK_DIV_25MHZ_10MS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_pulse,
  output logic               sample_tick,
  output logic               evt_valid,
  output logic [ID_W-1:0]    evt_id,
  input  logic               evt_ready,
  output logic [NUM_BTN-1:0] pending,
  output logic               overflow,
  input  logic               overflow_clr
);

  localparam int            CNT_W     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam int            FAW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [FAW:0]  FIFO_FULL = FIFO_DEPTH[FAW:0];

  logic [CNT_W-1:0]   tick_cnt;
  logic [ID_W-1:0]    last_grant;
  logic               grant_vld;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    scan_idx;
  logic [NUM_BTN-1:0] grant_oh;
  logic [NUM_BTN-1:0] pending_nxt;
  logic [NUM_BTN-1:0] merge;
  logic [FAW:0]       fifo_count;
  logic               fifo_empty;

  // Tick generator: decode of the registered counter, high for one cycle per period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign sample_tick = (tick_cnt == TICK_LAST);

  // Round-robin search starting just above the last winner. Gating on the
  // registered count means a pop in this cycle cannot free a slot for a push.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    grant_oh  = '0;
    if ((fifo_count < FIFO_FULL) && (|pending)) begin
      for (int j = 1; j <= NUM_BTN; j++) begin
        scan_idx = ID_W'((int'(last_grant) + j) % NUM_BTN);
        if (!grant_vld && pending[scan_idx]) begin
          grant_vld = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
    if (grant_vld) begin
      grant_oh[grant_idx] = 1'b1;
    end
  end

  // A pulse on the bit being granted re-arms it; a pulse on a bit that is
  // still waiting is lost and flagged.
  always_comb begin
    pending_nxt = (pending & ~grant_oh) | btn_pulse;
    merge       = btn_pulse & pending & ~grant_oh;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      overflow   <= 1'b0;
      last_grant <= ID_W'(NUM_BTN - 1);
    end else begin
      pending <= pending_nxt;
      if (|merge) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
      if (grant_vld) begin
        last_grant <= grant_idx;
      end
    end
  end

  sync_fifo #(
    .WIDTH (ID_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (grant_vld),
    .push_dat (grant_idx),
    .pop      (evt_ready & ~fifo_empty),
    .pop_dat  (evt_id),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign evt_valid = ~fifo_empty;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed bench for button_event_scheduler with a short tick period.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: evt_ready driven per scenario to fill and drain the event FIFO.
module tb_button_event_scheduler;
  import btn_pkg::*;

  localparam int NB = 4;
  localparam int IW = 2;
  localparam int FD = 4;
  localparam int TD = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_pulse;
  logic          sample_tick;
  logic          evt_valid;
  logic [IW-1:0] evt_id;
  logic          evt_ready;
  logic [NB-1:0] pending;
  logic          overflow;
  logic          overflow_clr;

  int      checks = 0;
  int      fails  = 0;
  btn_id_t got[$];

  button_event_scheduler #(
    .NUM_BTN    (NB),
    .ID_W       (IW),
    .FIFO_DEPTH (FD),
    .TICK_DIV   (TD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_pulse    (btn_pulse),
    .sample_tick  (sample_tick),
    .evt_valid    (evt_valid),
    .evt_id       (evt_id),
    .evt_ready    (evt_ready),
    .pending      (pending),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #20 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn_pulse = '0;
    evt_ready = 1'b0;
    overflow_clr = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic pulse(input logic [NB-1:0] b);
    btn_pulse = b;
    cyc();
    btn_pulse = '0;
  endtask

  // Records accepted events until n are seen or the cycle budget runs out.
  task automatic collect(input int n);
    got.delete();
    for (int c = 0; c < 40 && got.size() < n; c++) begin
      if (evt_valid && evt_ready) got.push_back(evt_id);
      cyc();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_pulse = '0;
    evt_ready = 1'b0;
    overflow_clr = 1'b0;
    cyc();
    cyc();
    checks++; if (sample_tick !== 1'b0) begin fails++; $display("FAIL rst_tick: got %b exp 0", sample_tick); end
    checks++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b exp 0", evt_valid); end
    checks++; if (evt_id !== 2'd0) begin fails++; $display("FAIL rst_id: got %0d exp 0", evt_id); end
    checks++; if (pending !== 4'b0000) begin fails++; $display("FAIL rst_pending: got %b exp 0000", pending); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL rst_overflow: got %b exp 0", overflow); end
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      checks++;
      if (sample_tick !== ((k % TD) == 0)) begin
        fails++; $display("FAIL tick_cycle_%0d: got %b exp %b", k, sample_tick, (k % TD) == 0);
      end
      cyc();
    end
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    checks++; if (sample_tick !== 1'b0) begin fails++; $display("FAIL tick_midreset: got %b exp 0", sample_tick); end
    cyc();
    cyc();
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      checks++;
      if (sample_tick !== (k == TD)) begin
        fails++; $display("FAIL tick_restart_%0d: got %b exp %b", k, sample_tick, k == TD);
      end
      cyc();
    end
  endtask

  task automatic test_single();
    do_reset();
    evt_ready = 1'b1;
    pulse(4'b0100);
    checks++; if (pending !== 4'b0100) begin fails++; $display("FAIL single_pend_t1: got %b exp 0100", pending); end
    checks++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL single_valid_t1: got %b exp 0", evt_valid); end
    cyc();
    checks++; if (evt_valid !== 1'b1) begin fails++; $display("FAIL single_valid_t2: got %b exp 1", evt_valid); end
    checks++; if (evt_id !== 2'd2) begin fails++; $display("FAIL single_id_t2: got %0d exp 2", evt_id); end
    checks++; if (pending !== 4'b0000) begin fails++; $display("FAIL single_pend_t2: got %b exp 0000", pending); end
    cyc();
    checks++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL single_valid_t3: got %b exp 0", evt_valid); end
  endtask

  task automatic test_round_robin();
    btn_id_t e2 [2];
    do_reset();
    evt_ready = 1'b1;
    pulse(4'b1111);
    collect(4);
    checks++; if (got.size() !== 4) begin fails++; $display("FAIL rr_count: got %0d exp 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== btn_id_t'(i)) begin fails++; $display("FAIL rr_order_%0d: got %0d exp %0d", i, got[i], i); end
    end
    e2[0] = 2'd0;
    e2[1] = 2'd3;
    pulse(4'b1001);
    collect(2);
    checks++; if (got.size() !== 2) begin fails++; $display("FAIL rr_wrap_count: got %0d exp 2", got.size()); end
    for (int i = 0; i < 2 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== e2[i]) begin fails++; $display("FAIL rr_wrap_%0d: got %0d exp %0d", i, got[i], e2[i]); end
    end
  endtask

  task automatic test_backpressure();
    btn_id_t e5 [5];
    do_reset();
    pulse(4'b0001);
    pulse(4'b0010);
    pulse(4'b0100);
    pulse(4'b1000);
    pulse(4'b0010);
    cyc();
    checks++; if (dut.u_fifo.count !== 3'd4) begin fails++; $display("FAIL bp_count: got %0d exp 4", dut.u_fifo.count); end
    checks++; if (pending !== 4'b0010) begin fails++; $display("FAIL bp_pending: got %b exp 0010", pending); end
    checks++; if (evt_valid !== 1'b1) begin fails++; $display("FAIL bp_valid: got %b exp 1", evt_valid); end
    checks++; if (evt_id !== 2'd0) begin fails++; $display("FAIL bp_head: got %0d exp 0", evt_id); end
    cyc();
    cyc();
    checks++; if (evt_id !== 2'd0) begin fails++; $display("FAIL bp_head_stable: got %0d exp 0", evt_id); end
    checks++; if (pending !== 4'b0010) begin fails++; $display("FAIL bp_pending_held: got %b exp 0010", pending); end
    e5[0] = 2'd0; e5[1] = 2'd1; e5[2] = 2'd2; e5[3] = 2'd3; e5[4] = 2'd1;
    evt_ready = 1'b1;
    collect(5);
    checks++; if (got.size() !== 5) begin fails++; $display("FAIL bp_drain_count: got %0d exp 5", got.size()); end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== e5[i]) begin fails++; $display("FAIL bp_drain_%0d: got %0d exp %0d", i, got[i], e5[i]); end
    end
    checks++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL bp_empty: got %b exp 0", evt_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    pulse(4'b0001);
    pulse(4'b0010);
    pulse(4'b0100);
    pulse(4'b1000);
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_fill: got %b exp 0", overflow); end
    pulse(4'b0100);
    cyc();
    pulse(4'b0100);
    checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b exp 1", overflow); end
    checks++; if (pending !== 4'b0100) begin fails++; $display("FAIL ovf_pending: got %b exp 0100", pending); end
    overflow_clr = 1'b1;
    cyc();
    overflow_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %b exp 0", overflow); end
    overflow_clr = 1'b1;
    pulse(4'b0100);
    overflow_clr = 1'b0;
    checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set_wins: got %b exp 1", overflow); end
    checks++; if (pending !== 4'b0100) begin fails++; $display("FAIL ovf_pending2: got %b exp 0100", pending); end
    evt_ready = 1'b1;
    collect(5);
    checks++; if (got.size() !== 5) begin fails++; $display("FAIL ovf_drain_count: got %0d exp 5", got.size()); end
    if (got.size() == 5) begin
      checks++; if (got[4] !== 2'd2) begin fails++; $display("FAIL ovf_drain_last: got %0d exp 2", got[4]); end
    end
  endtask

  task automatic test_push_pop();
    do_reset();
    pulse(4'b0001);
    pulse(4'b0010);
    pulse(4'b1000);
    checks++; if (dut.u_fifo.count !== 3'd2) begin fails++; $display("FAIL pp_count_pre: got %0d exp 2", dut.u_fifo.count); end
    checks++; if (evt_id !== 2'd0) begin fails++; $display("FAIL pp_head_pre: got %0d exp 0", evt_id); end
    evt_ready = 1'b1;
    cyc();
    evt_ready = 1'b0;
    checks++; if (dut.u_fifo.count !== 3'd2) begin fails++; $display("FAIL pp_count_post: got %0d exp 2", dut.u_fifo.count); end
    checks++; if (evt_id !== 2'd1) begin fails++; $display("FAIL pp_head_post: got %0d exp 1", evt_id); end
    cyc();
    checks++; if (evt_id !== 2'd1) begin fails++; $display("FAIL pp_head_stable: got %0d exp 1", evt_id); end
    evt_ready = 1'b1;
    collect(2);
    checks++; if (got.size() !== 2) begin fails++; $display("FAIL pp_drain_count: got %0d exp 2", got.size()); end
    if (got.size() == 2) begin
      checks++; if (got[0] !== 2'd1) begin fails++; $display("FAIL pp_order_0: got %0d exp 1", got[0]); end
      checks++; if (got[1] !== 2'd3) begin fails++; $display("FAIL pp_order_1: got %0d exp 3", got[1]); end
    end
  endtask

  task automatic test_midstream_reset();
    evt_ready = 1'b0;
    pulse(4'b0110);
    pulse(4'b0110);
    checks++; if (evt_valid !== 1'b1) begin fails++; $display("FAIL mr_valid_pre: got %b exp 1", evt_valid); end
    checks++; if (evt_id !== 2'd1) begin fails++; $display("FAIL mr_id_pre: got %0d exp 1", evt_id); end
    checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL mr_ovf_pre: got %b exp 1", overflow); end
    checks++; if (pending !== 4'b0110) begin fails++; $display("FAIL mr_pend_pre: got %b exp 0110", pending); end
    rst = 1'b1;
    #1;
    checks++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL mr_valid: got %b exp 0", evt_valid); end
    checks++; if (evt_id !== 2'd0) begin fails++; $display("FAIL mr_id: got %0d exp 0", evt_id); end
    checks++; if (pending !== 4'b0000) begin fails++; $display("FAIL mr_pending: got %b exp 0000", pending); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL mr_overflow: got %b exp 0", overflow); end
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_push_pop();
    test_midstream_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d fails=%0d", checks, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/button_event_scheduler.md
Name: button_event_scheduler

Overview:
Controller for the per-button debounce FSMs in the input path.
- Generates the shared sample tick that paces the debounce FSMs.
- Collects their one-cycle `debounced` pulses into per-button pending flags.
- Serialises the pulses through a round-robin arbiter into a small event FIFO.
- Presents one button-ID event at a time on a valid/ready interface to the game/display logic.
- Runs on the 25 MHz system clock.

Parameters:
- NUM_BTN, 4, number of debounced button inputs (2..8).
- ID_W, 2, width of the button index; must satisfy 2^ID_W >= NUM_BTN.
- FIFO_DEPTH, 4, event FIFO entries; power of two, 2..16.
- TICK_DIV, 250000, sample tick period in clk cycles (10 ms at 25 MHz); >= 2.

Ports:
- clk, input, 1, 25 MHz system clock.
- rst, input, 1, asynchronous active-high reset.
- btn_pulse, input, NUM_BTN, one-cycle debounced pulses, one bit per button.
- sample_tick, output, 1, one-cycle enable to the debounce FSMs, period TICK_DIV.
- evt_valid, output, 1, an event is available at the FIFO head.
- evt_id, output, ID_W, button index of the head event; valid only when evt_valid=1.
- evt_ready, input, 1, consumer accepts the event.
- pending, output, NUM_BTN, registered pending flags (debug/LEDs).
- overflow, output, 1, sticky: at least one pulse was merged/lost.
- overflow_clr, input, 1, synchronous clear of overflow.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. Asserting rst at any time (including mid-transfer) immediately clears all state.
- Reset values: sample_tick=0, evt_valid=0, evt_id=0, pending=0, overflow=0. Tick counter=0, FIFO empty, last_grant=NUM_BTN-1, so button 0 has first priority.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - sample_tick=1 exactly in the cycle the counter equals TICK_DIV-1.
  - First tick is TICK_DIV cycles after reset release.
- Pending flags, per bit i:
  - Set on btn_pulse[i]; clear when granted.
  - Pulse and grant of the same i in the same cycle: bit stays 1 (the new press is kept).
  - Pulse while pending[i]=1 and not granted that cycle: pulse merged, overflow<=1.
- Arbiter:
  - Operates on registered pending.
  - When pending != 0 and the FIFO is not full (registered count < FIFO_DEPTH): grant the first set bit searching from last_grant+1 upward, wrapping modulo NUM_BTN.
  - At most one grant per cycle.
  - On a grant: push the index into the FIFO, clear the pending bit, and update last_grant.
  - No grant while the FIFO is full. Pending bits are held, not dropped.
- FIFO:
  - evt_valid = !empty; evt_id = head entry.
  - Pop on evt_valid & evt_ready. evt_ready while empty is ignored.
  - Simultaneous push and pop when not full: count unchanged, order preserved.
  - Full is evaluated before the pop in the same cycle, so a push never occurs when count==FIFO_DEPTH, even if a pop happens that cycle.
  - Read and write pointers are ID-width-agnostic, log2(FIFO_DEPTH) bits, wrapping naturally.
- Latency: pulse in cycle t sets pending at edge t+1. Grant and push happen at edge t+2, so evt_valid is first high in cycle t+2 (empty FIFO, no contention).
- overflow:
  - Set as above; cleared by overflow_clr.
  - If set and clear occur in the same cycle, set wins.
- Valid/ready: evt_id must stay stable while evt_valid=1 and evt_ready=0.

Decomposition:
- Shared package btn_pkg: NUM_BTN/ID_W defaults, TICK_DIV_25MHZ_10MS=250000, and a btn_id_t typedef for the index.
- One natural sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty/count). The tick counter and round-robin arbiter stay inline.

Test Plan:
- Reset/tick: TICK_DIV=5. Release rst → sample_tick high at cycles 5, 10, 15 after release, low otherwise. Assert rst mid-count → counter restarts and the next tick is 5 cycles after release.
- Single press: btn_pulse=4'b0100 at cycle t, evt_ready=1 → evt_valid=1, evt_id=2 at t+2 for one cycle, then pending=0 and evt_valid=0.
- Round-robin: btn_pulse=4'b1111 for one cycle, evt_ready=1 → events in order 0, 1, 2, 3. Next 4'b1001 → order 0, 3 (last_grant=3 wraps to 0 first).
- Backpressure/full: FIFO_DEPTH=4, evt_ready=0, pulse buttons 0, 1, 2, 3 then 1 again → FIFO holds 0, 1, 2, 3; pending[1]=1 held; evt_id stays 0. Raise evt_ready → events 0, 1, 2, 3, 1 in order.
- Overflow: pulse button 2 twice while the FIFO is full → overflow=1 and pending[2]=1. overflow_clr for one cycle → overflow=0. overflow_clr coinciding with a merge → overflow stays 1.
- Simultaneous push/pop: FIFO count=2, evt_ready=1, new pulse → count stays 2 and event order preserved. Assert rst mid-stream → evt_valid=0, pending=0, overflow=0 immediately.
